updown_counter_mod: RTL and testbench

Parametrised up/down counter generalising the team's fixed 3-bit `up_down_counter`. It adds configurable width and modulus, a selectable wrap or saturate mode, count enable, synchronous parallel load, boundary flags, and a registered rollover pulse with a sticky overflow flag. It sits in the same counting and sequencing datapath and replaces the fixed counter wherever a non-power-of-two range or load capability is needed.

---
 rtl/updown_counter_mod_if.sv | 25 ++
 rtl/updown_counter_mod.sv | 61 ++++++
 tb/tb_updown_counter_mod.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_mod_if.sv
// updown_counter_mod_if: control inputs and status outputs of the up/down counter
interface updown_counter_mod_if #(
    parameter int WIDTH = 3
);
    logic             i_clear;
    logic             i_en;
    logic             i_dir_up;
    logic             i_load;
    logic [WIDTH-1:0] i_load_val;
    logic [WIDTH-1:0] o_count;
    logic             o_at_max;
    logic             o_at_min;
    logic             o_roll;
    logic             o_ovf;

    modport master (
        output i_clear, i_en, i_dir_up, i_load, i_load_val,
        input  o_count, o_at_max, o_at_min, o_roll, o_ovf
    );

    modport slave (
        input  i_clear, i_en, i_dir_up, i_load, i_load_val,
        output o_count, o_at_max, o_at_min, o_roll, o_ovf
    );
endinterface

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised wrap/saturate up/down counter with load,
// boundary flags, a registered rollover pulse and a sticky overflow flag.
module updown_counter_mod #(
    parameter int              WIDTH    = 3,
    parameter longint unsigned MOD_MAX  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input logic                 clk,
    input logic                 rst,
    updown_counter_mod_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD_MAX);

    logic [WIDTH-1:0] r_count;
    logic             r_roll;
    logic             r_ovf;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_bnd;
    logic [WIDTH-1:0] w_step;
    logic [WIDTH-1:0] w_wrap;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_load;

    assign w_at_max = r_count == MAX;
    assign w_at_min = r_count == '0;
    // The boundary path alone decides the value at the range edge, so the
    // truncated step below is never used there.
    assign w_bnd    = bus.i_dir_up ? w_at_max : w_at_min;
    assign w_step   = bus.i_dir_up ? r_count + 1'b1 : r_count - 1'b1;
    assign w_wrap   = bus.i_dir_up ? '0 : MAX;
    assign w_next   = w_bnd ? (SATURATE ? r_count : w_wrap) : w_step;
    assign w_load   = bus.i_load_val > MAX ? MAX : bus.i_load_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_roll  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.i_clear) begin
            r_count <= '0;
            r_roll  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (bus.i_load) begin
            r_count <= w_load;
            r_roll  <= 1'b0;
        end else if (bus.i_en) begin
            r_count <= w_next;
            r_roll  <= w_bnd;
            r_ovf   <= r_ovf | w_bnd;
        end else begin
            r_roll  <= 1'b0;
        end
    end

    assign bus.o_count  = r_count;
    assign bus.o_at_max = w_at_max;
    assign bus.o_at_min = w_at_min;
    assign bus.o_roll   = r_roll;
    assign bus.o_ovf    = r_ovf;
endmodule

// File: tb/tb_updown_counter_mod.sv
// tb_updown_counter_mod: four counter configurations checked every cycle against
// an arithmetic model, plus directed vectors with literal expectations.
module tb_updown_counter_mod;
    localparam int MX  [4] = '{7, 5, 7, 0};
    localparam bit SAT [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst;
    logic       clr [4];
    logic       en  [4];
    logic       up  [4];
    logic       ld  [4];
    logic [3:0] lv  [4];
    int         cnt [4];
    logic       amax[4];
    logic       amin[4];
    logic       roll[4];
    logic       ovf [4];
    int         mc  [4];
    bit         mr  [4];
    bit         mo  [4];
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    updown_counter_mod_if #(.WIDTH(3)) if0 ();
    updown_counter_mod_if #(.WIDTH(3)) if1 ();
    updown_counter_mod_if #(.WIDTH(3)) if2 ();
    updown_counter_mod_if #(.WIDTH(2)) if3 ();

    updown_counter_mod #(.WIDTH(3))                              u0 (.clk(clk), .rst(rst), .bus(if0));
    updown_counter_mod #(.WIDTH(3), .MOD_MAX(5))                 u1 (.clk(clk), .rst(rst), .bus(if1));
    updown_counter_mod #(.WIDTH(3), .MOD_MAX(7), .SATURATE(1'b1)) u2 (.clk(clk), .rst(rst), .bus(if2));
    updown_counter_mod #(.WIDTH(2), .MOD_MAX(0))                 u3 (.clk(clk), .rst(rst), .bus(if3));

    assign if0.i_clear = clr[0]; assign if0.i_en = en[0]; assign if0.i_dir_up = up[0];
    assign if0.i_load = ld[0];   assign if0.i_load_val = lv[0][2:0];
    assign if1.i_clear = clr[1]; assign if1.i_en = en[1]; assign if1.i_dir_up = up[1];
    assign if1.i_load = ld[1];   assign if1.i_load_val = lv[1][2:0];
    assign if2.i_clear = clr[2]; assign if2.i_en = en[2]; assign if2.i_dir_up = up[2];
    assign if2.i_load = ld[2];   assign if2.i_load_val = lv[2][2:0];
    assign if3.i_clear = clr[3]; assign if3.i_en = en[3]; assign if3.i_dir_up = up[3];
    assign if3.i_load = ld[3];   assign if3.i_load_val = lv[3][1:0];

    assign cnt[0] = int'(if0.o_count); assign amax[0] = if0.o_at_max; assign amin[0] = if0.o_at_min;
    assign roll[0] = if0.o_roll;       assign ovf[0] = if0.o_ovf;
    assign cnt[1] = int'(if1.o_count); assign amax[1] = if1.o_at_max; assign amin[1] = if1.o_at_min;
    assign roll[1] = if1.o_roll;       assign ovf[1] = if1.o_ovf;
    assign cnt[2] = int'(if2.o_count); assign amax[2] = if2.o_at_max; assign amin[2] = if2.o_at_min;
    assign roll[2] = if2.o_roll;       assign ovf[2] = if2.o_ovf;
    assign cnt[3] = int'(if3.o_count); assign amax[3] = if3.o_at_max; assign amin[3] = if3.o_at_min;
    assign roll[3] = if3.o_roll;       assign ovf[3] = if3.o_ovf;

    // A step hits the boundary when it would leave the range 0..MX.
    function automatic bit hits_edge(int k);
        return up[k] ? (mc[k] == MX[k]) : (mc[k] == 0);
    endfunction

    // Wrap mode is plain modular arithmetic; saturate mode clamps to the range.
    function automatic int stepped(int k);
        if (SAT[k])
            return hits_edge(k) ? mc[k] : mc[k] + (up[k] ? 1 : -1);
        return (mc[k] + (up[k] ? 1 : MX[k])) % (MX[k] + 1);
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst) begin
                mc[k] <= 0; mr[k] <= 1'b0; mo[k] <= 1'b0;
            end else if (clr[k]) begin
                mc[k] <= 0; mr[k] <= 1'b0; mo[k] <= 1'b0;
            end else if (ld[k]) begin
                mc[k] <= (int'(lv[k]) > MX[k]) ? MX[k] : int'(lv[k]);
                mr[k] <= 1'b0;
            end else if (en[k]) begin
                mc[k] <= stepped(k);
                mr[k] <= hits_edge(k);
                mo[k] <= mo[k] | hits_edge(k);
            end else begin
                mr[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string n, input int k, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t got=%0d want=%0d", n, k, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("model_count", k, cnt[k], mc[k]);
            chk("model_at_max", k, int'(amax[k]), int'(mc[k] == MX[k]));
            chk("model_at_min", k, int'(amin[k]), int'(mc[k] == 0));
            chk("model_roll", k, int'(roll[k]), int'(mr[k]));
            chk("model_ovf", k, int'(ovf[k]), int'(mo[k]));
        end
    end

    task automatic lit(input int k, input int c, input int r, input int o);
        chk("lit_count", k, cnt[k], c);
        chk("lit_roll", k, int'(roll[k]), r);
        chk("lit_ovf", k, int'(ovf[k]), o);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clr[k] = 1'b0; en[k] = 1'b0; up[k] = 1'b0; ld[k] = 1'b0; lv[k] = 4'd0;
        end
        #100;
        rst = 1'b1;
        #1;
        lit(0, 0, 0, 0);
        chk("rst_at_min", 0, int'(amin[0]), 1);
        chk("rst_at_max", 0, int'(amax[0]), 0);
        chk("deg_at_max", 3, int'(amax[3]), 1);
        chk("deg_at_min", 3, int'(amin[3]), 1);
        tick(); tick();
        lit(0, 0, 0, 0);

        en[1] = 1'b1; up[1] = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            lit(1, i, 0, 0);
        end
        chk("wrap_at_max", 1, int'(amax[1]), 1);
        tick(); lit(1, 0, 1, 1);
        en[1] = 1'b0;
        tick(); lit(1, 0, 0, 1);

        ld[1] = 1'b1; lv[1] = 4'd2;
        tick(); lit(1, 2, 0, 1);
        ld[1] = 1'b0; en[1] = 1'b1; up[1] = 1'b0;
        tick(); lit(1, 1, 0, 1);
        tick(); lit(1, 0, 0, 1);
        tick(); lit(1, 5, 1, 1);
        tick(); lit(1, 4, 0, 1);
        up[1] = 1'b1;
        tick(); lit(1, 5, 0, 1);
        tick(); lit(1, 0, 1, 1);
        en[1] = 1'b0;

        ld[2] = 1'b1; lv[2] = 4'd6;
        tick(); lit(2, 6, 0, 0);
        ld[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
        tick(); lit(2, 7, 0, 0);
        tick(); lit(2, 7, 1, 1);
        tick(); lit(2, 7, 1, 1);
        up[2] = 1'b0;
        tick(); lit(2, 6, 0, 1);
        en[2] = 1'b0;

        clr[1] = 1'b1;
        tick(); lit(1, 0, 0, 0);
        clr[1] = 1'b0; ld[1] = 1'b1; lv[1] = 4'd7;
        tick(); lit(1, 5, 0, 0);
        en[1] = 1'b1; up[1] = 1'b1; lv[1] = 4'd5;
        tick(); lit(1, 5, 0, 0);
        ld[1] = 1'b0;
        tick(); lit(1, 0, 1, 1);
        clr[1] = 1'b1; ld[1] = 1'b1; lv[1] = 4'd3;
        tick(); lit(1, 0, 0, 0);
        clr[1] = 1'b0; ld[1] = 1'b0; en[1] = 1'b0;
        tick(); lit(1, 0, 0, 0);

        en[3] = 1'b1; up[3] = 1'b1;
        tick(); lit(3, 0, 1, 1);
        up[3] = 1'b0;
        tick(); lit(3, 0, 1, 1);
        en[3] = 1'b0;
        tick(); lit(3, 0, 0, 1);
        ld[3] = 1'b1; lv[3] = 4'd3;
        tick(); lit(3, 0, 0, 1);
        ld[3] = 1'b0;

        ld[0] = 1'b1; lv[0] = 4'd7;
        tick(); lit(0, 7, 0, 0);
        ld[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
        tick(); lit(0, 0, 1, 1);
        ld[0] = 1'b1;
        tick(); lit(0, 7, 0, 1);
        ld[0] = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        lit(0, 0, 0, 0);
        chk("async_at_min", 0, int'(amin[0]), 1);
        tick(); lit(0, 0, 0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        tick(); lit(0, 1, 0, 0);
        en[0] = 1'b0;
        tick(); lit(0, 1, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
